fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register of the pipelined MIPS core.
- Owns the PC and fetches from instruction memory over a req/ack handshake.
- Presents the instruction word to the decode/register-read stage.
- Stalls when decode drops its hazard-ok signal, and flushes/redirects on taken branch or jump.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INST, 32'h0000_0000, instruction word inserted as a bubble (sll $0,$0,0).

Ports:
- clock  input  1  system clock; all state updates on posedge.
- reset  input  1  reset, synchronous, active-high.
- id_ready  input  1  hazard-ok from decode (regok); 0 = decode stalled, IF/ID must hold.
- redirect  input  1  taken branch/jump resolved downstream this cycle.
- redirect_pc  input  32  target PC; bits [1:0] ignored (forced 0).
- imem_req  output  1  fetch request; held until imem_ack.
- imem_addr  output  32  fetch address; stable while imem_req=1 and no ack.
- imem_ack  input  1  one-cycle response strobe; may arrive in the same cycle as imem_req (zero-wait).
- imem_rdata  input  32  instruction word, valid when imem_ack=1.
- ifid_inst  output  32  IF/ID instruction.
- ifid_pc4  output  32  IF/ID PC+4 of that instruction.
- ifid_valid  output  1  IF/ID holds a real instruction (0 = bubble).

Behaviour:
- Reset (posedge with reset=1; overrides everything):
  - pc=RESET_PC, state=FETCH.
  - ifid_inst=NOP_INST, ifid_pc4=0, ifid_valid=0.
  - Holding buffer cleared.
  - imem_req=0 while reset=1.
  - A reset mid-request abandons that request; the memory must tolerate an ack arriving after reset, and that ack is ignored.
- States:
  - FETCH: imem_req=1, imem_addr=pc.
  - HOLD: a fetched instruction is parked in buf/buf_pc4 because decode is stalled. imem_req=0.
  - DRAIN: an abandoned request is still outstanding. imem_req=1, imem_addr=drain_addr.
- "advance" = id_ready. When advance=0 and there is no redirect, ifid_* hold exactly.
- Priority: reset > redirect > stall > normal.
- FETCH, no redirect:
  - ack & advance: IF/ID <= {imem_rdata, pc+4, 1}; pc <= pc+4; stay in FETCH. Throughput is 1 instruction/cycle with zero-wait memory.
  - ack & !advance: buf <= imem_rdata, buf_pc4 <= pc+4; pc <= pc+4; go to HOLD. IF/ID unchanged.
  - !ack & advance: IF/ID <= bubble {NOP_INST, 0, 0}.
  - !ack & !advance: hold.
- HOLD, no redirect:
  - advance: IF/ID <= {buf, buf_pc4, 1}; go to FETCH (the next fetch issues in the following cycle).
  - !advance: hold.
- Redirect (any state):
  - pc <= {redirect_pc[31:2], 2'b00}.
  - IF/ID <= bubble, even if id_ready=0 (flush beats stall).
  - buf discarded.
  - If in FETCH with imem_req=1 and no ack this cycle: drain_addr <= pc (old), go to DRAIN.
  - If the ack coincides with the redirect, rdata is discarded and the next state is FETCH.
  - HOLD -> FETCH.
- DRAIN:
  - On ack: discard rdata, go to FETCH.
  - A redirect while in DRAIN updates pc only; stay in DRAIN.
  - Without redirect, IF/ID behaves as in FETCH with !ack: bubble if advance, else hold.
- Arithmetic: pc+4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 0. The PC is always word-aligned.
- Single outstanding request maximum; no speculative prefetch.

Decomposition:
- Shared package `pipe_pkg`:
  - NOP_INST constant.
  - fetch state enum {FETCH, HOLD, DRAIN}.
  - Opcode constants (BEQ 6'b000100, RTYPE 6'b000000, SW 6'b101011), already used by the decode hazard logic.
- One natural sub-module: `ifid_reg`, the IF/ID register with load/flush/hold controls. The FSM, PC and buffer stay in fetch_stage.

Test Plan:
- Zero-wait streaming: reset then release, imem_ack tied to imem_req, rdata=addr^32'hA5A5_0000 -> imem_addr 0,4,8,12 on consecutive cycles; ifid_pc4 4,8,12 one cycle later; ifid_valid=1 continuously.
- Stall: id_ready=0 for 3 cycles while an ack returns at pc=8 -> IF/ID frozen at pc4=8; state HOLD with buf_pc4=12; imem_req=0; after id_ready=1, ifid_pc4=12 next cycle, then fetch resumes at 12.
- Redirect with 2-cycle memory latency: request at 0x10 pending, redirect_pc=0x40 -> IF/ID bubble; DRAIN keeps imem_addr=0x10 until ack; that data never reaches IF/ID; next request at 0x40.
- Redirect during stall: state HOLD, id_ready=0, redirect_pc=0x103 -> ifid_valid=0, buf discarded, next imem_addr=0x100.
- Wrap and reset: pc=32'hFFFF_FFFC acked -> ifid_pc4=0 and next imem_addr=0; then reset asserted mid-request -> imem_req=0 and ifid_valid=0; after release, first imem_addr=RESET_PC.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: bubble encoding, fetch FSM states, opcodes.
package pipe_pkg;

    // sll $0,$0,0 encodes as all zeros and is the canonical bubble.
    localparam logic [31:0] NOP_INST = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_e;

    // Opcodes consumed by the decode hazard logic.
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_SW    = 6'b101011;

endpackage

// File: rtl/fetch_stage_ifid_reg.sv
// IF/ID pipeline register: flush inserts a bubble, load captures, else hold.
module ifid_reg #(
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        load_i,
    input  logic        flush_i,
    input  logic [31:0] inst_i,
    input  logic [31:0] pc4_i,
    output logic [31:0] inst_o,
    output logic [31:0] pc4_o,
    output logic        valid_o
);

    logic [31:0] inst_q;
    logic [31:0] pc4_q;
    logic        valid_q;

    // Flush wins over load so a redirect always squashes the slot.
    always_ff @(posedge clock_i) begin
        if (reset_i || flush_i) begin
            inst_q  <= NOP_INST;
            pc4_q   <= 32'h0;
            valid_q <= 1'b0;
        end else if (load_i) begin
            inst_q  <= inst_i;
            pc4_q   <= pc4_i;
            valid_q <= 1'b1;
        end
    end

    assign inst_o  = inst_q;
    assign pc4_o   = pc4_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, talks req/ack to imem, feeds IF/ID.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        id_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ifid_inst,
    output logic [31:0] ifid_pc4,
    output logic        ifid_valid
);
    import pipe_pkg::*;

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  buf_q, buf_d;
    logic [31:0]  buf_pc4_q, buf_pc4_d;
    logic [31:0]  drain_q, drain_d;

    logic         ack_v;
    logic [31:0]  pc_plus4;
    logic         ld, fl;
    logic [31:0]  ld_inst, ld_pc4;

    // Request is a pure function of state; it never depends on ack, so a
    // memory that ties ack to req combinationally does not form a loop.
    assign imem_req  = !reset && (state_q != ST_HOLD);
    assign imem_addr = (state_q == ST_DRAIN) ? drain_q : pc_q;
    assign ack_v     = imem_ack && imem_req;
    assign pc_plus4  = pc_q + 32'd4;

    // Next-state, PC, holding buffer and IF/ID control.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        buf_d     = buf_q;
        buf_pc4_d = buf_pc4_q;
        drain_d   = drain_q;
        ld        = 1'b0;
        fl        = 1'b0;
        ld_inst   = imem_rdata;
        ld_pc4    = pc_plus4;
        if (redirect) begin
            pc_d      = redirect_pc & ~32'h3;
            fl        = 1'b1;
            buf_d     = 32'h0;
            buf_pc4_d = 32'h0;
            unique case (state_q)
                ST_FETCH: begin
                    // Un-acked request must still be consumed before refetching.
                    if (!ack_v) begin
                        drain_d = pc_q;
                        state_d = ST_DRAIN;
                    end
                end
                ST_HOLD:  state_d = ST_FETCH;
                ST_DRAIN: if (ack_v) state_d = ST_FETCH;
                default:  state_d = ST_FETCH;
            endcase
        end else begin
            unique case (state_q)
                ST_FETCH: begin
                    if (ack_v) begin
                        pc_d = pc_plus4;
                        if (id_ready) begin
                            ld = 1'b1;
                        end else begin
                            buf_d     = imem_rdata;
                            buf_pc4_d = pc_plus4;
                            state_d   = ST_HOLD;
                        end
                    end else if (id_ready) begin
                        fl = 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (id_ready) begin
                        ld      = 1'b1;
                        ld_inst = buf_q;
                        ld_pc4  = buf_pc4_q;
                        state_d = ST_FETCH;
                    end
                end
                ST_DRAIN: begin
                    if (ack_v) state_d = ST_FETCH;
                    if (id_ready) fl = 1'b1;
                end
                default: state_d = ST_FETCH;
            endcase
        end
    end

    // State registers; synchronous reset abandons any in-flight request.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_FETCH;
            pc_q      <= RESET_PC;
            buf_q     <= 32'h0;
            buf_pc4_q <= 32'h0;
            drain_q   <= 32'h0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            buf_q     <= buf_d;
            buf_pc4_q <= buf_pc4_d;
            drain_q   <= drain_d;
        end
    end

    ifid_reg #(
        .NOP_INST (NOP_INST)
    ) u_ifid (
        .clock_i (clock),
        .reset_i (reset),
        .load_i  (ld),
        .flush_i (fl),
        .inst_i  (ld_inst),
        .pc4_i   (ld_pc4),
        .inst_o  (ifid_inst),
        .pc4_o   (ifid_pc4),
        .valid_o (ifid_valid)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: scoreboarded zero-wait stream, per-cycle vector
// table for stall/redirect/drain, and a hand-written wrap + reset sequence.
module tb_fetch_stage;

    localparam logic [31:0] K = 32'hA5A5_0000;

    logic        clock = 1'b0;
    logic        reset;
    logic        id_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] ifid_inst;
    logic [31:0] ifid_pc4;
    logic        ifid_valid;

    // zw=1: zero-wait memory answering every request in the same cycle.
    logic        zw;
    logic        m_ack;
    logic [31:0] m_rdata;

    assign imem_ack   = zw ? imem_req : m_ack;
    assign imem_rdata = zw ? (imem_addr ^ K) : m_rdata;

    fetch_stage #(
        .RESET_PC (32'h0000_0000),
        .NOP_INST (32'h0000_0000)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .id_ready    (id_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .ifid_inst   (ifid_inst),
        .ifid_pc4    (ifid_pc4),
        .ifid_valid  (ifid_valid)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] D(input logic [31:0] a);
        return a ^ K;
    endfunction

    // Scoreboard for the streaming phase.
    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc4;
    } exp_t;
    exp_t        sbq[$];
    logic        mon_en = 1'b0;
    logic        pv     = 1'b0;
    logic [31:0] ppc4   = 32'h0;

    // Pop one expected entry each time a new valid instruction lands in IF/ID.
    always @(negedge clock) begin
        if (mon_en) begin
            if (ifid_valid && (!pv || ifid_pc4 != ppc4)) begin
                if (sbq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_unexpected actual=%h required=none", ifid_pc4);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("sb_inst", ifid_inst, e.inst);
                    chk("sb_pc4", ifid_pc4, e.pc4);
                end
            end
            pv   <= ifid_valid;
            ppc4 <= ifid_pc4;
        end else begin
            pv   <= 1'b0;
            ppc4 <= 32'h0;
        end
    end

    typedef struct {
        logic        rdy;
        logic        rd;
        logic [31:0] rpc;
        logic        ack;
        logic [31:0] rdat;
        logic        ereq;
        logic [31:0] eaddr;
        logic        ev;
        logic [31:0] einst;
        logic [31:0] epc4;
    } vec_t;

    function automatic vec_t mk(input logic rdy, input logic rd, input logic [31:0] rpc,
                                input logic ack, input logic [31:0] rdat,
                                input logic ereq, input logic [31:0] eaddr,
                                input logic ev, input logic [31:0] einst, input logic [31:0] epc4);
        vec_t v;
        v.rdy = rdy; v.rd = rd; v.rpc = rpc; v.ack = ack; v.rdat = rdat;
        v.ereq = ereq; v.eaddr = eaddr; v.ev = ev; v.einst = einst; v.epc4 = epc4;
        return v;
    endfunction

    // One cycle: drive at negedge, check request side, then IF/ID after posedge.
    task automatic step(input vec_t v, input string nm);
        @(negedge clock);
        reset = 1'b0; zw = 1'b0;
        id_ready = v.rdy; redirect = v.rd; redirect_pc = v.rpc;
        m_ack = v.ack; m_rdata = v.rdat;
        #1;
        chk({nm, "_req"}, {31'h0, imem_req}, {31'h0, v.ereq});
        if (v.ereq) chk({nm, "_addr"}, imem_addr, v.eaddr);
        @(posedge clock);
        #1;
        chk({nm, "_valid"}, {31'h0, ifid_valid}, {31'h0, v.ev});
        chk({nm, "_inst"}, ifid_inst, v.einst);
        chk({nm, "_pc4"}, ifid_pc4, v.epc4);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1; zw = 1'b0; m_ack = 1'b0; m_rdata = 32'h0;
        id_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        @(posedge clock);
        @(posedge clock);
        #1;
    endtask

    vec_t tbl[18];

    initial begin
        // Stall, redirect with pending request, redirect during stall,
        // redirect coinciding with ack.
        tbl[0]  = mk(1, 0, 0,     1, D(0),         1, 32'h0,   1, D(0),     32'h4);
        tbl[1]  = mk(1, 0, 0,     1, D(4),         1, 32'h4,   1, D(4),     32'h8);
        tbl[2]  = mk(0, 0, 0,     1, D(8),         1, 32'h8,   1, D(4),     32'h8);
        tbl[3]  = mk(0, 0, 0,     0, 0,            0, 0,       1, D(4),     32'h8);
        tbl[4]  = mk(0, 0, 0,     0, 0,            0, 0,       1, D(4),     32'h8);
        tbl[5]  = mk(1, 0, 0,     0, 0,            0, 0,       1, D(8),     32'hC);
        tbl[6]  = mk(1, 0, 0,     1, D(12),        1, 32'hC,   1, D(12),    32'h10);
        tbl[7]  = mk(1, 0, 0,     0, 0,            1, 32'h10,  0, 0,        0);
        tbl[8]  = mk(1, 1, 32'h40, 0, 0,           1, 32'h10,  0, 0,        0);
        tbl[9]  = mk(1, 0, 0,     0, 0,            1, 32'h10,  0, 0,        0);
        tbl[10] = mk(1, 0, 0,     1, 32'hDEADBEEF, 1, 32'h10,  0, 0,        0);
        tbl[11] = mk(1, 0, 0,     1, D(32'h40),    1, 32'h40,  1, D(32'h40), 32'h44);
        tbl[12] = mk(0, 0, 0,     1, D(32'h44),    1, 32'h44,  1, D(32'h40), 32'h44);
        tbl[13] = mk(0, 1, 32'h103, 0, 0,          0, 0,       0, 0,        0);
        tbl[14] = mk(0, 0, 0,     0, 0,            1, 32'h100, 0, 0,        0);
        tbl[15] = mk(1, 0, 0,     1, D(32'h100),   1, 32'h100, 1, D(32'h100), 32'h104);
        tbl[16] = mk(1, 1, 32'h200, 1, 32'h11111111, 1, 32'h104, 0, 0,      0);
        tbl[17] = mk(1, 0, 0,     1, D(32'h200),   1, 32'h200, 1, D(32'h200), 32'h204);

        // Reset state.
        do_reset();
        chk("rst_req", {31'h0, imem_req}, 32'h0);
        chk("rst_valid", {31'h0, ifid_valid}, 32'h0);
        chk("rst_inst", ifid_inst, 32'h0);
        chk("rst_pc4", ifid_pc4, 32'h0);

        // Zero-wait streaming: one instruction per cycle.
        for (int i = 0; i < 6; i++) begin
            exp_t e;
            e.inst = D(32'(4 * i));
            e.pc4  = 32'(4 * i + 4);
            sbq.push_back(e);
        end
        mon_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            reset = 1'b0; zw = 1'b1; id_ready = 1'b1;
            #1;
            chk("str_req", {31'h0, imem_req}, 32'h1);
            chk("str_addr", imem_addr, 32'(4 * i));
            if (i > 0) chk("str_valid", {31'h0, ifid_valid}, 32'h1);
        end
        @(negedge clock);
        #2;
        mon_en = 1'b0;
        chk("sb_empty", 32'(sbq.size()), 32'h0);

        // Table-driven multi-cycle vectors from a fresh reset.
        do_reset();
        for (int i = 0; i < 18; i++) step(tbl[i], $sformatf("v%0d", i));

        // PC wrap at the top of the address space.
        step(mk(1, 1, 32'hFFFF_FFFF, 1, 32'h2222_2222, 1, 32'h204, 0, 0, 0), "wrap_redir");
        step(mk(1, 0, 0, 1, D(32'hFFFF_FFFC), 1, 32'hFFFF_FFFC, 1, D(32'hFFFF_FFFC), 32'h0), "wrap_fetch");
        step(mk(1, 0, 0, 0, 0, 1, 32'h0, 0, 0, 0), "wrap_next");

        // Reset while the request at 0 is outstanding, with a late ack.
        @(negedge clock);
        reset = 1'b1; m_ack = 1'b0;
        #1;
        chk("rmid_req", {31'h0, imem_req}, 32'h0);
        @(negedge clock);
        m_ack = 1'b1; m_rdata = 32'h3333_3333;
        #1;
        chk("rmid_req2", {31'h0, imem_req}, 32'h0);
        @(posedge clock);
        #1;
        chk("rmid_valid", {31'h0, ifid_valid}, 32'h0);
        step(mk(1, 0, 0, 0, 0, 1, 32'h0, 0, 0, 0), "rel_first");
        step(mk(1, 0, 0, 1, D(0), 1, 32'h0, 1, D(0), 32'h4), "rel_fetch");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
